// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one 16-entry LIFO between two clients.
// It tracks occupancy, rejects overflow and underflow, and returns pop data with a registered ack.
module stack_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    op,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          op_q, op_d;
  logic          legal_q, legal_d;
  logic          last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          stk_push_q, stk_push_d;
  logic          stk_pop_q, stk_pop_d;
  logic [DW-1:0] stk_din_q, stk_din_d;

  logic [1:0]    eff_req;
  logic          gnt_id;
  logic          gnt_op;
  logic          gnt_legal;
  logic [DW-1:0] gnt_wdata;

  // The client being acked still holds req during its ack cycle; mask it so it is not re-granted.
  assign eff_req = req & ~ack_q;

  always_comb begin
    gnt_id = 1'b0;
    case (eff_req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    gnt_op    = op[gnt_id];
    gnt_wdata = gnt_id ? wdata1 : wdata0;
    gnt_legal = gnt_op ? (count_q != DEPTH_C) : (count_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    op_d       = op_q;
    legal_d    = legal_q;
    last_d     = last_q;
    count_d    = count_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ack_d      = 2'b00;
    stk_push_d = 1'b0;
    stk_pop_d  = 1'b0;
    stk_din_d  = '0;
    case (state_q)
      IDLE: begin
        if (|eff_req) begin
          win_d      = gnt_id;
          last_d     = gnt_id;
          op_d       = gnt_op;
          legal_d    = gnt_legal;
          stk_push_d = gnt_legal & gnt_op;
          stk_pop_d  = gnt_legal & ~gnt_op;
          stk_din_d  = (gnt_legal && gnt_op) ? gnt_wdata : '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (legal_q) count_d = op_q ? count_q + 1'b1 : count_q - 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        err_d = ~legal_q;
        if (legal_q && !op_q) rdata_d = stk_dout;
        state_d = DONE;
      end
      DONE: begin
        ack_d[win_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      op_q       <= 1'b0;
      legal_q    <= 1'b0;
      last_q     <= 1'b1;
      count_q    <= '0;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
      stk_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      op_q       <= op_d;
      legal_q    <= legal_d;
      last_q     <= last_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      stk_push_q <= stk_push_d;
      stk_pop_q  <= stk_pop_d;
      stk_din_q  <= stk_din_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign stk_push = stk_push_q;
  assign stk_pop  = stk_pop_q;
  assign stk_din  = stk_din_q;

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one 16-entry LIFO stack between two requesters using round-robin arbitration.
- Sequences the stack's single-cycle push/pop strobes.
- Tracks occupancy, because the stack itself has no full/empty protection.
- Rejects overflow and underflow requests with an error response, and returns pop data through a registered ack handshake.

Parameters:
- DW, 8, data width; must match the stack data width.
- DEPTH, 16, stack capacity in entries.
- CW, 5, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  request per client; bit i = client i.
- op  in  2  operation per client: 1 = push, 0 = pop.
- wdata0  in  DW  push data, client 0.
- wdata1  in  DW  push data, client 1.
- ack  out  2  one-cycle completion pulse per client.
- err  out  1  valid with ack; 1 = request rejected (overflow or underflow).
- rdata  out  DW  pop data, valid with ack when err=0 and op was pop.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_din  out  DW  push data to the stack.
- stk_dout  in  DW  stack read data; registered, valid the cycle after stk_pop.

Behaviour:
- Reset values (async, rst high): state=IDLE, ack=0, err=0, rdata=0, stk_push=0, stk_pop=0, stk_din=0, count=0, last=1 (so client 0 wins first). The stack instance shares the same rst so its pointer realigns.
- All outputs are registered. full and empty are decoded from registered count.
- FSM states: IDLE, ISSUE, WAIT, DONE. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - If any req bit is high, select a winner and latch its id, op and wdata; then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - One requester: that requester wins.
  - Both requesting: the client != last wins; last is updated to the winner.
- Legality check, in IDLE at grant time: push is illegal if count==DEPTH; pop is illegal if count==0.
- ISSUE:
  - Legal push: stk_push=1 and stk_din=latched wdata for exactly this cycle; count increments at the end of the cycle.
  - Legal pop: stk_pop=1 for exactly this cycle; count decrements at the end of the cycle.
  - Illegal request: no strobe and count unchanged.
  - stk_push and stk_pop are never both high.
- WAIT: stk_dout is valid. At the end of the cycle, rdata captures stk_dout for a legal pop; otherwise rdata holds its value. err is set per the legality check. Next state is DONE.
- DONE: ack[winner]=1 for exactly one cycle, with err and rdata valid. Next state is IDLE.
- Latency: a request sampled at edge E0 in IDLE produces its ack during the cycle after edge E3. One operation is in flight at a time. Minimum request-to-request spacing is 4 cycles.
- Requester rules:
  - Hold req, op and wdata stable from assertion until ack.
  - Drop req on the edge at which ack is sampled, so it is low in the following IDLE cycle.
  - req changes outside IDLE are ignored; data is latched at grant time.
- Client ordering: stack order is global. A pop returns the most recent push by either client.
- Counter arithmetic: count never wraps. Saturation is enforced by the legality check, not by clamping.
- Reset mid-operation: any state returns to IDLE immediately. Strobes and ack drop asynchronously. The in-flight operation is lost and produces no ack.

Test Plan:
- After reset, client 0: push 0xA5 then pop -> 1st ack[0] err=0, count 0->1; 2nd ack[0] err=0, rdata=0xA5, count 1->0; stk_push and stk_pop each high for exactly one cycle, 1 cycle after grant.
- Both req high from reset, both push (wdata0=0x11, wdata1=0x22) -> client 0 acked first, then client 1; stack holds 0x11 below 0x22; two pops return 0x22 then 0x11.
- Pop on empty -> ack with err=1, no stk_pop pulse, count stays 0, rdata unchanged.
- 16 pushes of 0x00..0x0F -> full=1, count=16; 17th push -> err=1, no stk_push; 16 pops return 0x0F down to 0x00, then empty=1.
- Both clients continuously requesting, 8 operations -> grants alternate 0,1,0,1,…; each ack is 4 cycles after its grant; no grant is issued while not in IDLE.
- rst pulse during ISSUE of a pop with count=3 -> count=0, ack never asserted, state IDLE; next push/pop pair round-trips correctly.
